// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the local-history branch predictor.
//   bp_state_e : table-init / running state of the predictor
//   sat_inc    : saturating increment of a counter of width w (w <= 4)
//   sat_dec    : saturating decrement (floors at 0)
//   lht_index  : LHT index from a PC (word-aligned slice above bit 1)
package bp_pkg;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

  // Widest counter the helpers handle.
  localparam int unsigned BP_CTR_MAX_W = 4;

  function automatic logic [BP_CTR_MAX_W-1:0] sat_inc(input logic [BP_CTR_MAX_W-1:0] c,
                                                      input int unsigned w);
    logic [BP_CTR_MAX_W-1:0] mx;
    mx = BP_CTR_MAX_W'((5'd1 << w) - 5'd1);
    return (c >= mx) ? mx : c + 4'd1;
  endfunction

  function automatic logic [BP_CTR_MAX_W-1:0] sat_dec(input logic [BP_CTR_MAX_W-1:0] c,
                                                      input int unsigned w);
    // Width is irrelevant for the floor, kept for a symmetric call site.
    logic [BP_CTR_MAX_W-1:0] unused_w;
    unused_w = BP_CTR_MAX_W'(w);
    return (c == '0 || unused_w == '0) ? '0 : c - 4'd1;
  endfunction

  function automatic logic [31:0] lht_index(input logic [63:0] pc, input int unsigned idx_w);
    return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
  endfunction

endpackage

// File: rtl/bp_sat_ctr_next.sv
// bp_sat_ctr_next: next value of a saturating 2-level-predictor counter.
//   c_i     : current counter
//   taken_i : resolved outcome (1 = increment, 0 = decrement)
//   c_o     : saturated next counter
module bp_sat_ctr_next
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] c_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] c_o
);

  logic [BP_CTR_MAX_W-1:0] c_ext;

  assign c_ext = BP_CTR_MAX_W'(c_i);

  always_comb begin
    c_o = CTR_W'(sat_dec(c_ext, CTR_W));
    if (taken_i) c_o = CTR_W'(sat_inc(c_ext, CTR_W));
  end

endmodule

// File: rtl/local_hist_pred_p.sv
// local_hist_pred_p: two-level local-history branch predictor.
//   PC slice -> LHT history register -> PHT saturating counter -> prediction.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   fetch_pc / pred : fetch-stage lookup, pred=1 means taken (combinational)
//   upd_valid/pc/taken : resolved branch, accepted once ready is high
//   ready           : tables initialised after the post-reset sweep
// Optional macro BP_FETCH_BYPASS_EN: fetch lookup also sees the update
// currently pending in the write stage, one cycle earlier than the array.
module local_hist_pred_p
  import bp_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int LHT_IDX_W = 3,
  parameter int HIST_W    = 3,
  parameter int CTR_W     = 2,
  parameter int CTR_INIT  = 2**CTR_W - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            ready
);

  localparam int LHT_N   = 2**LHT_IDX_W;
  localparam int PHT_N   = 2**HIST_W;
  localparam int SWEEP_N = (LHT_N > PHT_N) ? LHT_N : PHT_N;
  localparam int PTR_W   = $clog2(SWEEP_N) + 1;
  localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);

  bp_state_e        state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             ready_q;

  logic [HIST_W-1:0] lht_q [LHT_N];
  logic [CTR_W-1:0]  pht_q [PHT_N];

  // Update stage U: old history/counter of the branch, written next cycle.
  logic                 u_vld_q;
  logic [LHT_IDX_W-1:0] u_idx_q;
  logic [HIST_W-1:0]    u_hist_q;
  logic [CTR_W-1:0]     u_ctr_q;
  logic                 u_taken_q;
  logic [HIST_W-1:0]    u_nhist;
  logic [CTR_W-1:0]     u_nctr;

  logic [LHT_IDX_W-1:0] up_idx, f_idx;
  logic [HIST_W-1:0]    up_hist, f_hist;
  logic [CTR_W-1:0]     up_ctr, f_ctr;

  // Outcome shifts in at the MSB.
  assign u_nhist = (u_hist_q >> 1) | (HIST_W'(u_taken_q) << (HIST_W-1));

  bp_sat_ctr_next #(.CTR_W(CTR_W)) u_ctr_next (
    .c_i     (u_ctr_q),
    .taken_i (u_taken_q),
    .c_o     (u_nctr)
  );

  assign up_idx = LHT_IDX_W'(lht_index(64'(upd_pc), LHT_IDX_W));
  assign f_idx  = LHT_IDX_W'(lht_index(64'(fetch_pc), LHT_IDX_W));

  // Read-after-write forwarding so back-to-back updates serialise exactly.
  always_comb begin
    up_hist = lht_q[up_idx];
    if (u_vld_q && u_idx_q == up_idx) up_hist = u_nhist;
    up_ctr = pht_q[up_hist];
    if (u_vld_q && u_hist_q == up_hist) up_ctr = u_nctr;
  end

  always_comb begin
    f_hist = lht_q[f_idx];
`ifdef BP_FETCH_BYPASS_EN
    if (u_vld_q && u_idx_q == f_idx) f_hist = u_nhist;
`endif
    f_ctr = pht_q[f_hist];
`ifdef BP_FETCH_BYPASS_EN
    if (u_vld_q && u_hist_q == f_hist) f_ctr = u_nctr;
`endif
  end

  assign pred  = (state_q == BP_RUN) ? f_ctr[CTR_W-1] : CTR_INIT_V[CTR_W-1];
  assign ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BP_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      u_vld_q <= 1'b0;
    end else begin
      u_vld_q <= 1'b0;
      case (state_q)
        BP_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PTR_W'(SWEEP_N-1)) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_RUN:  u_vld_q <= upd_valid;
        default: state_q <= BP_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid) begin
      u_idx_q   <= up_idx;
      u_hist_q  <= up_hist;
      u_ctr_q   <= up_ctr;
      u_taken_q <= upd_taken;
    end
  end

  // Tables carry no reset; the sweep initialises them. A write pending
  // when rst arrives is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == BP_INIT) begin
        if (ptr_q < PTR_W'(LHT_N)) lht_q[ptr_q[LHT_IDX_W-1:0]] <= '0;
        if (ptr_q < PTR_W'(PHT_N)) pht_q[ptr_q[HIST_W-1:0]]    <= CTR_INIT_V;
      end else if (u_vld_q) begin
        lht_q[u_idx_q]  <= u_nhist;
        pht_q[u_hist_q] <= u_nctr;
      end
    end
  end

endmodule

// File: doc/local_hist_pred_p.md
Name: local_hist_pred_p

Overview:
- Parametrised two-level local-history branch predictor for the fetch stage.
- Each PC slice selects a per-branch history register in the LHT; that history selects a saturating counter in the PHT.
- Generalises the existing 8x3/2-bit predictor in table depth, history length and counter width.
- Adds a registered update stage with read-after-write forwarding, and a post-reset table-initialisation sweep.

Parameters:
- PC_W, 32, PC width.
- LHT_IDX_W, 3, log2 of LHT entries; index = pc[LHT_IDX_W+1:2].
- HIST_W, 3, history bits per LHT entry; PHT has 2**HIST_W entries.
- CTR_W, 2, PHT counter width; legal range 1..4.
- CTR_INIT, 2**CTR_W-1, counter value after init (weakly/strongly taken).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fetch_pc  in  PC_W  PC being fetched.
- pred  out  1  prediction for fetch_pc; 1 = taken.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  resolved outcome.
- ready  out  1  tables initialised; updates accepted.

Behaviour:
- FSM states are INIT and RUN.
- rst=1 at a posedge: state<=INIT, sweep pointer<=0, pending stage cleared; ready=0, pred=CTR_INIT[CTR_W-1].
- INIT: one entry per cycle, LHT[ptr]<=0 if ptr<2**LHT_IDX_W, PHT[ptr]<=CTR_INIT if ptr<2**HIST_W.
  - Sweep lasts N=max(2**LHT_IDX_W, 2**HIST_W) cycles; then state<=RUN and ready<=1.
  - Defaults: ready rises on the 8th posedge after rst falls.
  - Updates arriving in INIT are dropped.
  - pred is held at CTR_INIT MSB for the whole of INIT.
- RUN, prediction: combinational.
  - h = LHT[fetch_pc idx]; pred = PHT[h][CTR_W-1].
- RUN, update stage U (posedge N, upd_valid=1):
  - Register idx, current history h (read at the upd_pc index, forwarded), current counter c = PHT[h] (forwarded), and upd_taken.
- RUN, write (posedge N+1):
  - LHT[idx]<={taken, h[HIST_W-1:1]}.
  - PHT[h]<=taken ? min(c+1, 2**CTR_W-1) : max(c-1, 0).
  - Saturating arithmetic; no wrap at 0 or max.
- Forwarding: if U is valid and the new update hits the same LHT idx, use the pending new history; same rule for the PHT index and pending new counter.
  - Back-to-back updates to one entry must behave exactly as if serialised.
- upd_valid every cycle is legal; throughput is 1 update/cycle; there is no backpressure in RUN.
- Fetch read and array write in the same cycle (no bypass): fetch sees pre-write contents.
- A pending U write in flight when rst asserts is discarded; the sweep restarts from 0.
- Aliasing is allowed: PCs sharing an LHT idx share history; no tags.

Optional Feature:
- Macro: BP_FETCH_BYPASS_EN.
- Defined: pred uses U's pending history/counter when fetch_pc hits U's idx or the resulting PHT index, so an update becomes visible one cycle earlier.
- Undefined: no bypass; visibility is after posedge N+1 as above.

Decomposition:
- Package bp_pkg holds the state enum (BP_INIT, BP_RUN), a sat_inc/sat_dec function pair parametrised by width, and an lht_index function.
- One sub-module, bp_sat_ctr_next: combinational next counter from c and taken.
- Tables and FSM stay in the top module.

Test Plan:
- Reset: rst 1 then 0 → ready=0 for 8 cycles, then 1; pred=1 throughout INIT for any fetch_pc.
- Single training, fetch_pc=0x10 held:
  - upd 0x10 not-taken twice, non-consecutive → PHT[0] goes 3→2→1.
  - pred=0 after the second write's posedge; LHT[4] stays 000.
- Back-to-back forwarding: upd 0x10 not-taken in two consecutive cycles → PHT[0]=1, not 2.
- History shift: upd 0x10 taken x3 → LHT[4] = 100, 110, 111.
  - fetch 0x10 then reads PHT[7]=3 → pred=1.
  - A following not-taken update writes PHT[7]=2.
- Reset mid-op: rst asserted the cycle after upd_valid → pending write lost; all tables re-swept; PHT[0]=3 afterwards.
- Bypass (BP_FETCH_BYPASS_EN), PHT[0]=2 initially:
  - upd 0x10 not-taken with fetch_pc=0x10 → pred=0 in the cycle after upd_valid.
  - Without the macro, pred=0 one cycle later.
